i2c_codec_slave: RTL and testbench

I2C write-only responder that models the audio codec's control port on the board-level I2C bus. It is the bus-side counterpart of the codec register configuration sequencer. It receives 3-byte writes (device address, then a 16-bit register word), acknowledges them, and stores the 9-bit payloads in a local register file. Two uses: the bench target for configuration-sequencer verification, and the on-chip shadow of codec settings exposed to the rest of the audio datapath.

---
 rtl/i2c_codec_slave.sv | 181 ++++++++++++++++++
 tb/tb_i2c_codec_slave.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_codec_slave.sv
// i2c_codec_slave: write-only I2C responder shadowing the audio codec control registers.
// Frame is {DEV_ADDR,W}, {reg_addr[6:0], data[8]}, data[7:0]; SCL/SDA are oversampled on clock_50m.
//
// state     | meaning
// IDLE      | bus free, or current transfer is not addressed to us
// ADDR      | shifting in the device address byte
// ACK_A     | holding SDA low for the address ack
// BYTE1     | shifting in {reg_addr, data[8]}
// ACK_1     | holding SDA low for the byte 1 ack
// BYTE2     | shifting in data[7:0]
// ACK_2     | holding SDA low for the byte 2 ack; commit on its closing SCL fall
// WAIT_STOP | write done; further bytes are refused until STOP/START
module i2c_codec_slave #(
    parameter logic [6:0] DEV_ADDR = 7'h1A,
    parameter int         NUM_REGS = 10
) (
    input  logic       clock_50m,
    input  logic       reset_n,
    input  logic       i2c_sclk,
    inout  wire        i2c_sdat,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       wr_stb,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    output logic       busy,
    output logic       err
);
    localparam int         AW        = $clog2(NUM_REGS);
    localparam logic [6:0] REG_LIMIT = 7'(NUM_REGS);
    localparam logic [7:0] WR_BYTE   = {DEV_ADDR, 1'b0};

    typedef enum logic [2:0] {
        IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, WAIT_STOP
    } state_t;

    state_t     state, state_nx;
    logic       scl_meta, scl_sync, scl_d;
    logic       sda_meta, sda_sync, sda_d;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [3:0] bit_cnt, bit_cnt_nx;
    logic [7:0] shift, shift_nx;
    logic [7:0] byte1, byte1_nx;
    logic       sda_oe, sda_oe_nx;
    logic       extra_seen, extra_nx;
    logic       err_nx, commit;
    logic [8:0] regs [NUM_REGS];

    // Synchronizers reset to the idle-bus level so release from reset creates no edges.
    always_ff @(posedge clock_50m or negedge reset_n) begin
        if (!reset_n) begin
            {scl_meta, scl_sync, scl_d} <= 3'b111;
            {sda_meta, sda_sync, sda_d} <= 3'b111;
        end else begin
            {scl_meta, scl_sync, scl_d} <= {i2c_sclk, scl_meta, scl_sync};
            {sda_meta, sda_sync, sda_d} <= {i2c_sdat, sda_meta, sda_sync};
        end
    end

    assign scl_rise  = scl_sync & ~scl_d;
    assign scl_fall  = ~scl_sync & scl_d;
    assign start_det = scl_sync & scl_d & sda_d & ~sda_sync;
    assign stop_det  = scl_sync & scl_d & ~sda_d & sda_sync;

    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        shift_nx   = shift;
        byte1_nx   = byte1;
        sda_oe_nx  = sda_oe;
        extra_nx   = extra_seen;
        err_nx     = 1'b0;
        commit     = 1'b0;
        if (start_det || stop_det) begin
            case (state)
                ADDR:                               err_nx = (bit_cnt != 4'd0);
                ACK_A, BYTE1, ACK_1, BYTE2, ACK_2:  err_nx = 1'b1;
                default:                            err_nx = 1'b0;
            endcase
            state_nx   = start_det ? ADDR : IDLE;
            bit_cnt_nx = 4'd0;
            sda_oe_nx  = 1'b0;
            extra_nx   = 1'b0;
        end else begin
            case (state)
                ADDR, BYTE1, BYTE2: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        shift_nx   = {shift[6:0], sda_sync};
                        bit_cnt_nx = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt_nx = 4'd0;
                        sda_oe_nx  = 1'b1;
                        case (state)
                            ADDR: begin
                                if (shift == WR_BYTE) begin
                                    state_nx = ACK_A;
                                end else begin
                                    state_nx  = IDLE;
                                    sda_oe_nx = 1'b0;
                                end
                            end
                            BYTE1: begin
                                state_nx = ACK_1;
                                byte1_nx = shift;
                            end
                            default: state_nx = ACK_2;
                        endcase
                    end
                end
                ACK_A, ACK_1, ACK_2: begin
                    if (scl_fall) begin
                        sda_oe_nx = 1'b0;
                        case (state)
                            ACK_A:   state_nx = BYTE1;
                            ACK_1:   state_nx = BYTE2;
                            default: begin
                                state_nx = WAIT_STOP;
                                commit   = 1'b1;
                            end
                        endcase
                    end
                end
                WAIT_STOP: begin
                    // Extra bytes are framed as 8 data + 1 ack clock; only the first one flags err.
                    if (scl_rise && bit_cnt != 4'd9) begin
                        shift_nx   = {shift[6:0], sda_sync};
                        bit_cnt_nx = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        err_nx   = ~extra_seen;
                        extra_nx = 1'b1;
                    end else if (scl_fall && bit_cnt == 4'd9) begin
                        bit_cnt_nx = 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock_50m or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            bit_cnt    <= 4'd0;
            shift      <= 8'd0;
            byte1      <= 8'd0;
            sda_oe     <= 1'b0;
            extra_seen <= 1'b0;
            err        <= 1'b0;
            wr_stb     <= 1'b0;
            wr_addr    <= 7'd0;
            wr_data    <= 9'd0;
        end else begin
            state      <= state_nx;
            bit_cnt    <= bit_cnt_nx;
            shift      <= shift_nx;
            byte1      <= byte1_nx;
            sda_oe     <= sda_oe_nx;
            extra_seen <= extra_nx;
            err        <= err_nx;
            wr_stb     <= commit;
            if (commit) begin
                wr_addr <= byte1[7:1];
                wr_data <= {byte1[0], shift};
            end
        end
    end

    // Register file is loaded from the committed outputs, one cycle behind wr_stb.
    always_ff @(posedge clock_50m or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 9'd0;
        end else if (wr_stb && wr_addr < REG_LIMIT) begin
            regs[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data  = ({3'b000, rd_addr} < REG_LIMIT) ? regs[rd_addr[AW-1:0]] : 9'd0;
    assign busy     = (state != IDLE);
    assign i2c_sdat = sda_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_codec_slave.sv
// Bench for i2c_codec_slave: bit-banged I2C master, random transfers checked against
// a register-file model built from the transfer rules (who acks, what gets stored).
module tb_i2c_codec_slave;
    localparam int         NREG   = 10;
    localparam logic [7:0] DEV_WR = 8'h34;

    logic       clock_50m = 1'b0;
    logic       reset_n   = 1'b0;
    logic       scl       = 1'b1;
    logic       m_low     = 1'b0;
    wire        sda_bus;
    logic [3:0] rd_addr   = 4'd0;
    logic [8:0] rd_data;
    logic       wr_stb, busy, err;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;

    int n_tests = 0, n_fail = 0;
    int stb_seen = 0, err_seen = 0, drv_seen = 0;
    int exp_stb = 0, exp_err = 0;
    logic [6:0] exp_addr = 7'd0;
    logic [8:0] exp_data = 9'd0;
    logic [8:0] m_regs [NREG];
    logic [15:0] seq [10] = '{16'h001F, 16'h021F, 16'h0479, 16'h0679, 16'h08F8,
                              16'h0A06, 16'h0C00, 16'h0E01, 16'h1002, 16'h1201};

    assign sda_bus = m_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_codec_slave dut (
        .clock_50m (clock_50m),
        .reset_n   (reset_n),
        .i2c_sclk  (scl),
        .i2c_sdat  (sda_bus),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_stb    (wr_stb),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .err       (err)
    );

    always #10 clock_50m = ~clock_50m;

    always @(posedge clock_50m) begin
        #2;
        if (wr_stb === 1'b1) stb_seen++;
        if (err === 1'b1) err_seen++;
        if (!m_low && sda_bus === 1'b0) drv_seen++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock_50m);
    endtask

    task automatic bus_start();
        m_low = 1'b0; cyc(5);
        scl   = 1'b1; cyc(5);
        m_low = 1'b1; cyc(5);
        scl   = 1'b0; cyc(5);
    endtask

    task automatic bus_stop();
        m_low = 1'b1; cyc(5);
        scl   = 1'b1; cyc(5);
        m_low = 1'b0; cyc(5);
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            m_low = ~b[i]; cyc(5);
            scl   = 1'b1;  cyc(10);
            scl   = 1'b0;  cyc(5);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        send_bits(b);
        m_low = 1'b0; cyc(5);
        scl   = 1'b1; cyc(5);
        acked = (sda_bus === 1'b0);
        cyc(5);
        scl   = 1'b0; cyc(5);
    endtask

    task automatic model_commit(input logic [7:0] b1, input logic [7:0] b2);
        exp_stb++;
        exp_addr = b1[7:1];
        exp_data = {b1[0], b2};
        if (int'(exp_addr) < NREG) m_regs[exp_addr] = exp_data;
    endtask

    task automatic check_state(input string tag);
        check_val({tag, "_stb_cnt"}, stb_seen, exp_stb);
        check_val({tag, "_err_cnt"}, err_seen, exp_err);
        check_val({tag, "_wr_addr"}, wr_addr, exp_addr);
        check_val({tag, "_wr_data"}, wr_data, exp_data);
        check_val({tag, "_busy"}, busy, 0);
    endtask

    task automatic check_regs(input string tag);
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            #1;
            check_val($sformatf("%s_reg%0d", tag, a), rd_data, (a < NREG) ? m_regs[a] : 9'd0);
        end
    endtask

    // Body of a transfer after START; ends with STOP.
    task automatic xfer(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input bit extra);
        logic ack;
        int   drv0;
        drv0 = drv_seen;
        send_byte(b0, ack);
        if (b0 != DEV_WR) begin
            check_val("nack_dev", ack, 0);
            check_val("busy_drop", busy, 0);
            check_val("no_drive", drv_seen - drv0, 0);
        end else begin
            check_val("ack_dev", ack, 1);
            check_val("busy_hi", busy, 1);
            send_byte(b1, ack);
            check_val("ack_b1", ack, 1);
            send_byte(b2, ack);
            check_val("ack_b2", ack, 1);
            model_commit(b1, b2);
            if (extra) begin
                send_byte(8'($urandom), ack);
                check_val("nack_extra", ack, 0);
                exp_err++;
            end
        end
        bus_stop();
        cyc(6);
        check_state("post");
    endtask

    task automatic write3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input bit extra);
        bus_start();
        xfer(b0, b1, b2, extra);
    endtask

    task automatic abort_after_b1(input logic [7:0] b1, input bit restart,
                                  input logic [7:0] nb1, input logic [7:0] nb2);
        logic ack;
        bus_start();
        send_byte(DEV_WR, ack);
        check_val("ab_ack_dev", ack, 1);
        send_byte(b1, ack);
        check_val("ab_ack_b1", ack, 1);
        exp_err++;
        if (restart) begin
            bus_start();
            xfer(DEV_WR, nb1, nb2, 1'b0);
        end else begin
            bus_stop();
            cyc(6);
            check_state("abort");
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic       ack;
        int         s0, e0, k;
        logic [6:0] a7;
        logic [8:0] d9;
        logic [7:0] b0;

        for (int i = 0; i < NREG; i++) m_regs[i] = 9'd0;
        cyc(5);
        check_val("rst_sda_released", sda_bus === 1'b1, 1);
        check_val("rst_wr_stb", wr_stb, 0);
        check_val("rst_err", err, 0);
        check_state("rst");
        check_regs("rst");
        reset_n = 1'b1;
        cyc(10);

        // single write to reg 0
        write3(DEV_WR, 8'h00, 8'h1F, 1'b0);
        rd_addr = 4'd0;
        #1;
        check_val("t1_reg0", rd_data, 9'h01F);
        check_val("t1_wr_data", wr_data, 9'h01F);

        // full configuration sequence
        s0 = stb_seen;
        e0 = err_seen;
        for (int i = 0; i < 10; i++) write3(DEV_WR, seq[i][15:8], seq[i][7:0], 1'b0);
        check_val("seq_stb", stb_seen - s0, 10);
        check_val("seq_err", err_seen - e0, 0);
        rd_addr = 4'd4; #1; check_val("seq_reg4", rd_data, 9'h0F8);
        rd_addr = 4'd7; #1; check_val("seq_reg7", rd_data, 9'h001);
        rd_addr = 4'd9; #1; check_val("seq_reg9", rd_data, 9'h001);
        check_regs("seq");

        // wrong device address and read bit
        write3(8'h36, 8'h00, 8'h00, 1'b0);
        write3(8'h35, 8'h00, 8'h00, 1'b0);

        // out-of-range register address is acked but not stored
        write3(DEV_WR, 8'h1E, 8'h00, 1'b0);
        check_val("oor_wr_addr", wr_addr, 7'h0F);
        check_regs("oor");

        // truncated transfers
        abort_after_b1(8'h08, 1'b0, 8'h00, 8'h00);
        check_regs("abort_stop");
        abort_after_b1(8'h08, 1'b1, 8'h06, 8'h5A);
        check_regs("abort_rs");

        // reset in the byte-2 ack slot
        bus_start();
        send_byte(DEV_WR, ack);
        send_byte(8'h02, ack);
        send_bits(8'hAA);
        m_low = 1'b0; cyc(5);
        scl   = 1'b1; cyc(2);
        check_val("rst_ack_low", sda_bus === 1'b0, 1);
        #3 reset_n = 1'b0;
        #1 check_val("rst_sda_z", sda_bus === 1'b1, 1);
        for (int i = 0; i < NREG; i++) m_regs[i] = 9'd0;
        exp_addr = 7'd0;
        exp_data = 9'd0;
        cyc(2);
        check_state("midrst");
        check_regs("midrst");
        cyc(2);
        reset_n = 1'b1;
        cyc(10);
        write3(DEV_WR, 8'h04, 8'h77, 1'b0);
        check_regs("after_rst");

        // randomized traffic
        for (int t = 0; t < 24; t++) begin
            k  = $urandom_range(0, 9);
            a7 = 7'($urandom_range(0, 15));
            d9 = 9'($urandom_range(0, 511));
            if (k <= 5) begin
                write3(DEV_WR, {a7, d9[8]}, d9[7:0], 1'b0);
            end else if (k == 6) begin
                b0 = 8'($urandom);
                if (b0 == DEV_WR) b0 = 8'h35;
                write3(b0, {a7, d9[8]}, d9[7:0], 1'b0);
            end else if (k == 7) begin
                abort_after_b1({a7, d9[8]}, 1'b0, 8'h00, 8'h00);
            end else if (k == 8) begin
                abort_after_b1(8'($urandom), 1'b1, {a7, d9[8]}, d9[7:0]);
            end else begin
                write3(DEV_WR, {a7, d9[8]}, d9[7:0], 1'b1);
            end
            if (t % 6 == 5) check_regs("rnd");
        end
        check_regs("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
